// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: fetch FSM states and the IF/ID stage payload.
package pipeline_pkg;

    localparam int PC_W    = 11;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]         HALT_OPCODE = 6'b111111;
    localparam logic [PC_W-1:0]    RESET_PC    = 11'd0;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

endpackage

// File: rtl/if_id_register.sv
// Generic stage register for if_id_t: bubble beats load, load beats hold.
module if_id_register
    import pipeline_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q <= IF_ID_BUBBLE;
        end else if (bubble) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC selection for an external pc_register, IF/ID capture, HALT handling.
// if_id_valid qualifies if_id_instr/if_id_pc; stall=1 means decode is not ready, so IF/ID and PC hold.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC_P    = RESET_PC,
    parameter logic [5:0]      HALT_OPCODE_P = HALT_OPCODE
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    pc_q,
    output logic [PC_W-1:0]    pc_next,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               halted,
    output fetch_state_t       debug_state
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t state, next_state;
    logic         load, bubble;
    logic         is_halt;
    if_id_t       if_id_d, if_id_q;

    assign imem_addr   = pc_q;
    assign is_halt     = (imem_rdata[INSTR_W-1 -: 6] == HALT_OPCODE_P);
    assign if_id_d     = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
    assign debug_state = state;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= S_BOOT;
            halted <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= (next_state == S_HALT);
        end
    end

    always_comb begin
        next_state = state;
        pc_next    = pc_q;
        load       = 1'b0;
        bubble     = 1'b0;
        case (state)
            S_BOOT: begin
                pc_next    = RESET_PC_P;
                bubble     = 1'b1;
                next_state = S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    pc_next = branch_target;
                    bubble  = 1'b1;
                end else if (!stall) begin
                    load = 1'b1;
                    if (is_halt) begin
                        // HALT still goes to decode; PC freezes on its address.
                        next_state = S_HALT;
                    end else begin
                        pc_next = pc_q + PC_ONE;
                    end
                end
            end
            S_HALT: begin
                bubble = 1'b1;
                if (flush) begin
                    pc_next    = branch_target;
                    next_state = S_RUN;
                end
            end
            default: begin
                pc_next    = RESET_PC_P;
                bubble     = 1'b1;
                next_state = S_BOOT;
            end
        endcase
        // pc_register has no reset, so it is steered to the boot address here.
        if (!reset_n) begin
            pc_next = RESET_PC_P;
        end
    end

    if_id_register u_if_id (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load),
        .bubble  (bubble),
        .d       (if_id_d),
        .q       (if_id_q)
    );

    assign if_id_instr = if_id_q.instr;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural pc_register and instruction ROM beside it.
module tb_fetch_stage;
    import pipeline_pkg::*;

    localparam int W = 58;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic               clock;
    logic               reset_n;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_next;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               flush;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;
    logic               if_id_valid;
    logic               halted;
    fetch_state_t       debug_state;

    logic [INSTR_W-1:0] rom [0:2047];
    logic [W-1:0]       exp_q [$];
    int                 checks;
    int                 errors;

    // clock / reset block, plus the pc_register and ROM that sit beside the stage
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) pc_q <= pc_next;
    assign imem_rdata = rom[imem_addr];

    fetch_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pc_q          (pc_q),
        .pc_next       (pc_next),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .debug_state   (debug_state)
    );

    function automatic logic [31:0] rom_word(input int a);
        return 32'h1000_0000 | 32'(a * 3 + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge view, then compare it.
    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] e_pcq,
                        input logic e_valid, input logic [PC_W-1:0] e_pc,
                        input logic [31:0] e_instr, input logic e_halt,
                        input fetch_state_t e_state);
        logic [W-1:0] e;
        reset_n       = rst;
        stall         = st;
        flush         = fl;
        branch_target = tgt;
        exp_q.push_back({e_state, e_halt, e_valid, e_pc, e_instr, e_pcq});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk("pc_q",        64'(pc_q),        64'(e[10:0]));
        chk("if_id_instr", 64'(if_id_instr), 64'(e[42:11]));
        chk("if_id_pc",    64'(if_id_pc),    64'(e[53:43]));
        chk("if_id_valid", 64'(if_id_valid), 64'(e[54]));
        chk("halted",      64'(halted),      64'(e[55]));
        chk("state",       64'(debug_state), 64'(e[57:56]));
        chk("imem_addr",   64'(imem_addr),   64'(pc_q));
    endtask

    task automatic run(input logic [PC_W-1:0] pc, input logic halt_next);
        step(1, 0, 0, 0, halt_next ? pc : pc + 11'd1, 1, pc, rom[pc], halt_next,
             halt_next ? S_HALT : S_RUN);
    endtask

    task automatic bubble_step(input logic st, input logic fl, input logic [PC_W-1:0] tgt,
                               input logic [PC_W-1:0] e_pcq, input logic e_halt,
                               input fetch_state_t e_state);
        step(1, st, fl, tgt, e_pcq, 0, 0, NOP_INSTR, e_halt, e_state);
    endtask

    task automatic reset_edge(input logic st);
        step(0, st, 0, 0, RESET_PC, 0, 0, NOP_INSTR, 0, S_BOOT);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2048; i++) rom[i] = rom_word(i);
        reset_n = 0; stall = 0; flush = 0; branch_target = '0;

        // reset for two edges, then boot and run from 0
        #1;
        chk("pc_next_in_reset", 64'(pc_next), 64'(RESET_PC));
        reset_edge(0);
        reset_edge(0);
        bubble_step(0, 0, 0, 0, 0, S_RUN);
        for (int p = 0; p < 5; p++) run(11'(p), 0);

        // stall three cycles at pc_q=5
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 5, 1, 4, rom[4], 0, S_RUN);
        for (int p = 5; p < 10; p++) run(11'(p), 0);

        // flush + stall together at pc_q=10
        bubble_step(1, 1, 11'd300, 11'd300, 0, S_RUN);
        run(11'd300, 0);
        run(11'd301, 0);

        // HALT at address 7
        rom[7] = HALT_WORD;
        bubble_step(0, 1, 11'd5, 11'd5, 0, S_RUN);
        run(11'd5, 0);
        run(11'd6, 0);
        step(1, 0, 0, 0, 7, 1, 7, HALT_WORD, 1, S_HALT);
        for (int i = 0; i < 10; i++) bubble_step(logic'(i % 2), 0, 0, 7, 1, S_HALT);
        bubble_step(1, 1, 11'd20, 11'd20, 0, S_RUN);
        run(11'd20, 0);
        run(11'd21, 0);

        // reset while halted
        bubble_step(0, 1, 11'd7, 11'd7, 0, S_RUN);
        step(1, 0, 0, 0, 7, 1, 7, HALT_WORD, 1, S_HALT);
        bubble_step(0, 0, 0, 7, 1, S_HALT);
        reset_edge(0);
        bubble_step(0, 0, 0, 0, 0, S_RUN);
        run(11'd0, 0);
        run(11'd1, 0);

        // reset while stalled
        step(1, 1, 0, 0, 2, 1, 1, rom[1], 0, S_RUN);
        reset_edge(1);
        bubble_step(1, 1, 11'd99, 0, 0, S_RUN);
        run(11'd0, 0);
        run(11'd1, 0);

        // PC wrap at the top of the instruction space
        rom[7] = rom_word(7);
        bubble_step(0, 1, 11'd2045, 11'd2045, 0, S_RUN);
        run(11'd2045, 0);
        run(11'd2046, 0);
        run(11'd2047, 0);
        run(11'd0, 0);
        run(11'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
